// File: rtl/nvme_ctrl_state.sv
// NVMe controller enable/shutdown sequencer.
// Owns CC and CSTS, drives queue-engine enable and reset.
module nvme_ctrl_state #(
  parameter int unsigned TO_UNIT_CYCLES = 16,
  parameter int unsigned INIT_CYCLES    = 8,
  parameter int unsigned SHN_CYCLES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic [3:0]  to,
  input  logic        idle_in,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic [31:0] cc,
  output logic [31:0] csts,
  output logic        ctrl_enabled,
  output logic        queue_reset
);

  localparam logic [15:0] CC_ADDR   = 16'h0014;
  localparam logic [15:0] CSTS_ADDR = 16'h001C;
  localparam logic [31:0] CFG_MASK  = 32'h00FF_3FF0;
  localparam logic [31:0] DYN_MASK  = 32'h0000_C001;
  localparam logic [7:0]  INIT_LD   = 8'(INIT_CYCLES);
  localparam logic [7:0]  SHN_LD    = 8'(SHN_CYCLES);
  localparam logic [19:0] TO_UNIT   = 20'(TO_UNIT_CYCLES);

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_ENABLING,
    ST_READY,
    ST_DISABLING,
    ST_SHDN_ACTIVE,
    ST_SHDN_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cc_q, cc_d;
  logic        rdy_q, rdy_d;
  logic        cfs_q, cfs_d;
  logic [1:0]  shst_q, shst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        shn_run_q, shn_run_d;
  logic [19:0] wd_q, wd_d;
  logic        qrst_q, qrst_d;

  logic        cc_wr;
  logic        wr_dis;
  logic        wd_exp;
  logic        wd_run;
  logic [3:0]  to_eff;
  logic [19:0] wd_lim;

  assign cc_wr  = wr_en && (addr == CC_ADDR);
  assign wr_dis = cc_wr && !wr_data[0];
  assign to_eff = (to == 4'd0) ? 4'd1 : to;
  assign wd_lim = 20'(to_eff) * TO_UNIT;
  assign wd_exp = (wd_q == wd_lim);

  always_comb begin
    cc_d      = cc_q;
    state_d   = state_q;
    rdy_d     = rdy_q;
    cfs_d     = cfs_q;
    shst_d    = shst_q;
    cnt_d     = cnt_q;
    shn_run_d = shn_run_q;

    // Config fields are frozen while the controller is enabled
    if (cc_wr) begin
      cc_d = (cc_q & ~DYN_MASK) | (wr_data & DYN_MASK);
      if (!cc_q[0]) begin
        cc_d = (cc_d & ~CFG_MASK) | (wr_data & CFG_MASK);
      end
    end

    unique case (state_q)
      ST_DISABLED: begin
        if (cc_wr && wr_data[0] && !cc_q[0]) begin
          if (wr_data[6:4] != 3'b000) begin
            cfs_d = 1'b1;
          end else begin
            state_d = ST_ENABLING;
            cnt_d   = INIT_LD;
          end
        end
      end
      ST_ENABLING: begin
        if (wr_dis) begin
          state_d = ST_DISABLING;
        end else if (cnt_q == 8'd1) begin
          state_d = ST_READY;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_READY: begin
        if (wr_dis) begin
          state_d = ST_DISABLING;
        end else if (cc_wr && wr_data[15:14] != 2'b00) begin
          state_d   = ST_SHDN_ACTIVE;
          shst_d    = 2'b01;
          shn_run_d = 1'b0;
        end
      end
      ST_DISABLING: begin
        if (idle_in || wd_exp) begin
          state_d = ST_DISABLED;
          rdy_d   = 1'b0;
          shst_d  = 2'b00;
          cfs_d   = cfs_q | ~idle_in;
        end
      end
      ST_SHDN_ACTIVE: begin
        if (wr_dis) begin
          state_d = ST_DISABLING;
        end else if (shn_run_q && cnt_q == 8'd1) begin
          state_d = ST_SHDN_DONE;
          shst_d  = 2'b10;
        end else if (wd_exp) begin
          state_d = ST_SHDN_DONE;
          shst_d  = 2'b10;
          cfs_d   = 1'b1;
        end else if (shn_run_q) begin
          cnt_d = cnt_q - 8'd1;
        end else if (idle_in) begin
          shn_run_d = 1'b1;
          cnt_d     = SHN_LD;
        end
      end
      ST_SHDN_DONE: begin
        if (wr_dis) begin
          state_d = ST_DISABLING;
        end
      end
      default: begin
        state_d = ST_DISABLED;
      end
    endcase

    // Watchdog restarts on every entry and only runs while waiting
    wd_run = (state_d == state_q) &&
             (state_q == ST_DISABLING || state_q == ST_SHDN_ACTIVE);
    wd_d   = wd_run ? wd_q + 20'd1 : 20'd0;
    qrst_d = (state_d == ST_DISABLING) && (state_q != ST_DISABLING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_DISABLED;
      cc_q      <= '0;
      rdy_q     <= 1'b0;
      cfs_q     <= 1'b0;
      shst_q    <= 2'b00;
      cnt_q     <= '0;
      shn_run_q <= 1'b0;
      wd_q      <= '0;
      qrst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cc_q      <= cc_d;
      rdy_q     <= rdy_d;
      cfs_q     <= cfs_d;
      shst_q    <= shst_d;
      cnt_q     <= cnt_d;
      shn_run_q <= shn_run_d;
      wd_q      <= wd_d;
      qrst_q    <= qrst_d;
    end
  end

  assign cc           = cc_q;
  assign csts         = {28'd0, shst_q, cfs_q, rdy_q};
  assign ctrl_enabled = (state_q == ST_READY);
  assign queue_reset  = qrst_q;
  assign rd_hit       = (addr == CC_ADDR) || (addr == CSTS_ADDR);

  always_comb begin
    rd_data = '0;
    if (addr == CC_ADDR) begin
      rd_data = cc_q;
    end else if (addr == CSTS_ADDR) begin
      rd_data = csts;
    end
  end

endmodule

// File: tb/tb_nvme_ctrl_state.sv
// Directed bench for nvme_ctrl_state: vector table
// plus hand sequences for watchdog and disable timing.
module tb_nvme_ctrl_state;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [3:0]  to;
  logic        idle_in;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [31:0] cc;
  logic [31:0] csts;
  logic        ctrl_enabled;
  logic        queue_reset;

  int total;
  int bad;

  nvme_ctrl_state #(
    .TO_UNIT_CYCLES(16),
    .INIT_CYCLES(8),
    .SHN_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .to(to),
    .idle_in(idle_in),
    .rd_data(rd_data),
    .rd_hit(rd_hit),
    .cc(cc),
    .csts(csts),
    .ctrl_enabled(ctrl_enabled),
    .queue_reset(queue_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] a;
    logic [31:0] d;
    logic        we;
    logic        idle;
    logic [31:0] ecc;
    logic [31:0] ecsts;
    logic        een;
    logic        eq;
  } vec_t;

  vec_t v[30];

  function automatic vec_t mk(
    input logic rst, input logic [15:0] a,
    input logic [31:0] d, input logic we,
    input logic idle, input logic [31:0] ecc,
    input logic [31:0] ecsts, input logic een,
    input logic eq);
    vec_t r;
    r.rst = rst; r.a = a; r.d = d; r.we = we;
    r.idle = idle; r.ecc = ecc; r.ecsts = ecsts;
    r.een = een; r.eq = eq;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] a,
                      input logic [31:0] d, input logic w,
                      input logic [3:0] t, input logic i);
    reset = r; addr = a; wr_data = d; wr_en = w;
    to = t; idle_in = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_enable(input logic [3:0] t);
    step(1'b1, 16'h1C, 32'h0, 1'b0, t, 1'b0);
    step(1'b0, 16'h14, 32'h1, 1'b1, t, 1'b0);
    repeat (8) step(1'b0, 16'h1C, 32'h0, 1'b0, t, 1'b0);
    chk("enable_rdy", csts, 32'h1);
    chk("enable_en", 32'(ctrl_enabled), 32'h1);
  endtask

  task automatic wd_run(input string nm, input logic [3:0] t,
                        input logic [31:0] wdat, input int exp_n,
                        input logic [31:0] exp_csts);
    int n;
    do_enable(t);
    step(1'b0, 16'h14, wdat, 1'b1, t, 1'b0);
    n = 0;
    for (int k = 1; k <= 100 && n == 0; k++) begin
      step(1'b0, 16'h1C, 32'h0, 1'b0, t, 1'b0);
      if (csts[1]) n = k;
    end
    chk({nm, "_edges"}, 32'(n), 32'(exp_n));
    chk({nm, "_csts"}, csts, exp_csts);
    chk({nm, "_en"}, 32'(ctrl_enabled), 32'h0);
  endtask

  initial begin
    logic [31:0] erd;
    logic        ehit;
    total = 0;
    bad = 0;
    reset = 1'b1; addr = 16'h0; wr_data = 32'h0;
    wr_en = 1'b0; to = 4'd1; idle_in = 1'b0;

    v[0]  = mk(1, 16'h1C, 32'h0,    0, 0, 32'h0,    32'h0, 0, 0);
    v[1]  = mk(1, 16'h14, 32'h1,    1, 0, 32'h0,    32'h0, 0, 0);
    v[2]  = mk(0, 16'h14, 32'h11,   1, 0, 32'h11,   32'h2, 0, 0);
    v[3]  = mk(0, 16'h1C, 32'h0,    0, 0, 32'h11,   32'h2, 0, 0);
    v[4]  = mk(0, 16'h14, 32'h0,    1, 0, 32'h10,   32'h2, 0, 0);
    v[5]  = mk(1, 16'h18, 32'h0,    0, 0, 32'h0,    32'h0, 0, 0);
    v[6]  = mk(0, 16'h14, 32'h1,    1, 0, 32'h1,    32'h0, 0, 0);
    v[7]  = mk(0, 16'h14, 32'h381,  1, 0, 32'h1,    32'h0, 0, 0);
    v[8]  = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[9]  = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[10] = mk(0, 16'h18, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[11] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[12] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[13] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[14] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h1, 1, 0);
    v[15] = mk(0, 16'h14, 32'h4001, 1, 0, 32'h4001, 32'h5, 0, 0);
    v[16] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h4001, 32'h5, 0, 0);
    v[17] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h4001, 32'h5, 0, 0);
    v[18] = mk(0, 16'h1C, 32'h0,    0, 1, 32'h4001, 32'h5, 0, 0);
    v[19] = mk(0, 16'h1C, 32'h0,    0, 1, 32'h4001, 32'h5, 0, 0);
    v[20] = mk(0, 16'h1C, 32'h0,    0, 1, 32'h4001, 32'h5, 0, 0);
    v[21] = mk(0, 16'h1C, 32'h0,    0, 1, 32'h4001, 32'h5, 0, 0);
    v[22] = mk(0, 16'h1C, 32'h0,    0, 1, 32'h4001, 32'h9, 0, 0);
    v[23] = mk(0, 16'h14, 32'h0,    1, 1, 32'h0,    32'h9, 0, 1);
    v[24] = mk(0, 16'h1C, 32'h0,    0, 1, 32'h0,    32'h0, 0, 0);
    v[25] = mk(0, 16'h14, 32'h1,    1, 0, 32'h1,    32'h0, 0, 0);
    v[26] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[27] = mk(0, 16'h14, 32'h0,    0, 0, 32'h1,    32'h0, 0, 0);
    v[28] = mk(1, 16'h14, 32'h0,    0, 0, 32'h0,    32'h0, 0, 0);
    v[29] = mk(0, 16'h1C, 32'h0,    0, 0, 32'h0,    32'h0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      step(v[i].rst, v[i].a, v[i].d, v[i].we, 4'd1, v[i].idle);
      ehit = (v[i].a == 16'h14) || (v[i].a == 16'h1C);
      erd  = (v[i].a == 16'h14) ? v[i].ecc :
             (v[i].a == 16'h1C) ? v[i].ecsts : 32'h0;
      chk($sformatf("v%0d_cc", i), cc, v[i].ecc);
      chk($sformatf("v%0d_csts", i), csts, v[i].ecsts);
      chk($sformatf("v%0d_en", i), 32'(ctrl_enabled), 32'(v[i].een));
      chk($sformatf("v%0d_qrst", i), 32'(queue_reset), 32'(v[i].eq));
      chk($sformatf("v%0d_rd", i), rd_data, erd);
      chk($sformatf("v%0d_hit", i), 32'(rd_hit), 32'(ehit));
    end

    // Disable from READY with the engine already idle
    do_enable(4'd1);
    step(1'b0, 16'h14, 32'h0, 1'b1, 4'd1, 1'b1);
    chk("dis_qrst1", 32'(queue_reset), 32'h1);
    chk("dis_csts1", csts, 32'h1);
    step(1'b0, 16'h1C, 32'h0, 1'b0, 4'd1, 1'b1);
    chk("dis_qrst2", 32'(queue_reset), 32'h0);
    chk("dis_csts2", csts, 32'h0);
    chk("dis_en", 32'(ctrl_enabled), 32'h0);

    // Disable while still enabling, engine busy one cycle
    step(1'b1, 16'h1C, 32'h0, 1'b0, 4'd1, 1'b0);
    step(1'b0, 16'h14, 32'h1, 1'b1, 4'd1, 1'b0);
    repeat (3) step(1'b0, 16'h1C, 32'h0, 1'b0, 4'd1, 1'b0);
    step(1'b0, 16'h14, 32'h0, 1'b1, 4'd1, 1'b0);
    chk("enx_qrst", 32'(queue_reset), 32'h1);
    step(1'b0, 16'h1C, 32'h0, 1'b0, 4'd1, 1'b1);
    chk("enx_qrst2", 32'(queue_reset), 32'h0);
    repeat (10) step(1'b0, 16'h1C, 32'h0, 1'b0, 4'd1, 1'b1);
    chk("enx_csts", csts, 32'h0);
    chk("enx_en", 32'(ctrl_enabled), 32'h0);

    wd_run("wd_to2", 4'd2, 32'h0, 33, 32'h2);
    wd_run("wd_to0", 4'd0, 32'h0, 17, 32'h2);
    wd_run("wd_shn", 4'd1, 32'h4001, 17, 32'hB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=done");
    $fatal(1, "timeout");
  end

endmodule
